// File: rtl/volt_frame_uart_pkg.sv
// volt_frame_uart_pkg: shared constants, FSM states and frame-byte helpers for the voltage UART
//   ASCII_*      fixed frame characters
//   FRAME_LEN    bytes per frame
//   state_t      frame FSM states
//   frame_char   byte at a given frame position
package volt_frame_uart_pkg;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_V     = 8'h56;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam int FRAME_LEN = 10;
    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
    function automatic logic [7:0] digit_ascii(input logic [3:0] n);
        return n > 4'd9 ? ASCII_QMARK : ASCII_ZERO + {4'd0, n};
    endfunction
    // Positions 1..6 hold five digits with the '.' after int_digits of them; k is the digit
    // number counted from the most significant nibble.
    function automatic logic [7:0] frame_char(input logic [3:0] idx, input logic [19:0] dec,
                                              input logic [7:0] sign, input int int_digits);
        logic [2:0] k;
        logic [3:0] nib;
        k = 32'(idx) <= int_digits ? 3'(idx - 4'd1) : 3'(idx - 4'd2);
        nib = 4'(dec >> (5'd16 - {k, 2'b00}));
        return idx == 4'd0 ? sign :
               idx == 4'd7 ? ASCII_V :
               idx == 4'd8 ? ASCII_CR :
               idx == 4'd9 ? ASCII_LF :
               32'(idx) == int_digits + 1 ? ASCII_DOT : digit_ascii(nib);
    endfunction
endpackage

// File: rtl/volt_frame_uart_if.sv
// volt_frame_uart_if: request/acknowledge and serial-line bundle between the sample FSM and the UART
//   dec       packed BCD voltage, dec[19:16] most significant
//   sign      ASCII sign character
//   uart_we   frame request level
//   tx_reg    serial line, idle high
//   uart_end  frame-complete acknowledge level
interface volt_frame_uart_if;
    logic [19:0] dec;
    logic [7:0]  sign;
    logic        uart_we;
    logic        tx_reg;
    logic        uart_end;
    modport master (output dec, sign, uart_we, input tx_reg, uart_end);
    modport slave  (input dec, sign, uart_we, output tx_reg, uart_end);
endinterface

// File: rtl/volt_frame_uart_byte_tx.sv
// volt_frame_uart_byte_tx: 8N1 serializer, LSB first, BIT_CYC clocks per bit
//   clk, rst_n  clock and asynchronous active-low reset
//   start/data  byte request; accepted when idle or in the final cycle of a stop bit
//   tx          serial line, idle high
//   busy        a byte is on the line
//   done        one-cycle pulse near the end of the stop bit
module volt_frame_uart_byte_tx #(
    parameter int BIT_CYC = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(BIT_CYC);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d, busy_q, busy_d;
    logic          bit_end, last;
    always_comb begin
        bit_end = cnt_q == CW'(BIT_CYC - 1);
        last    = busy_q && bit_q == 4'd9 && bit_end;
        // done leads the stop-bit end by two clocks so the requester's registered start
        // lands exactly on the boundary and bytes go out back-to-back.
        done    = busy_q && bit_q == 4'd9 && cnt_q == CW'(BIT_CYC - 3);
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        if (start && (!busy_q || last)) begin
            cnt_d  = '0;
            bit_d  = 4'd0;
            sh_d   = data;
            tx_d   = 1'b0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
                bit_d = bit_q == 4'd9 ? 4'd0 : bit_q + 4'd1;
                tx_d  = bit_q >= 4'd8 ? 1'b1 : sh_q[0];
                sh_d  = {1'b0, sh_q[7:1]};
                busy_d = bit_q != 4'd9;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            bit_q  <= 4'd0;
            sh_q   <= 8'd0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end
    assign tx   = tx_q;
    assign busy = busy_q;
endmodule

// File: rtl/volt_frame_uart.sv
// volt_frame_uart: sends "<sign>DD.DDDV\r\n" as UART 8N1 per uart_we/uart_end 4-phase handshake
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         slave side of volt_frame_uart_if (dec, sign, uart_we in; tx_reg, uart_end out)
module volt_frame_uart
    import volt_frame_uart_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int INT_DIGITS = 2
) (
    input logic              clk,
    input logic              rst_n,
    volt_frame_uart_if.slave bus
);
    localparam int BIT_CYC = CLK_FRE * 1000000 / BAUD_RATE;
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [19:0] dec_q, dec_d;
    logic [7:0]  sign_q, sign_d, byte_q, byte_d;
    logic        start_q, start_d, end_q, end_d;
    logic        busy, done;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        sign_d  = sign_q;
        byte_d  = byte_q;
        start_d = 1'b0;
        end_d   = end_q;
        case (state_q)
            IDLE: if (bus.uart_we && !end_q) begin
                dec_d   = bus.dec;
                sign_d  = bus.sign;
                idx_d   = 4'd0;
                state_d = LOAD;
            end
            LOAD: begin
                byte_d  = frame_char(idx_q, dec_q, sign_q, INT_DIGITS);
                start_d = 1'b1;
                state_d = SEND;
            end
            SEND: if (done) begin
                idx_d   = idx_q == 4'(FRAME_LEN - 1) ? idx_q : idx_q + 4'd1;
                state_d = idx_q == 4'(FRAME_LEN - 1) ? DONE : LOAD;
            end
            // Acknowledge only once the last stop bit is off the line; a request withdrawn
            // mid-frame returns to IDLE without ever raising uart_end.
            DONE: if (!busy) begin
                end_d   = bus.uart_we;
                state_d = bus.uart_we ? DONE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            dec_q   <= 20'd0;
            sign_q  <= 8'd0;
            byte_q  <= 8'd0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            sign_q  <= sign_d;
            byte_q  <= byte_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end
    volt_frame_uart_byte_tx #(.BIT_CYC(BIT_CYC)) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start_q),
        .data (byte_q),
        .tx   (bus.tx_reg),
        .busy (busy),
        .done (done)
    );
    assign bus.uart_end = end_q;
endmodule

// File: tb/tb_volt_frame_uart.sv
// tb_volt_frame_uart: frame table, line-decoding scoreboard and handshake/reset corner sequences
module tb_volt_frame_uart;
    localparam int B = 16;
    typedef struct {
        logic [19:0] dec;
        logic [7:0]  sign;
        logic [79:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cmp = 0;
    int errs = 0;
    int cyc = 0;
    int c0 = 0;
    int st_cyc = 0;
    logic mon_en = 1'b1;
    logic [7:0] exp_q[$];
    vec_t vecs[5];
    volt_frame_uart_if bif ();
    volt_frame_uart #(.CLK_FRE(2), .BAUD_RATE(125000), .INT_DIGITS(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask
    initial begin : monitor
        int nb;
        int prev;
        logic [7:0] b;
        logic stop;
        nb = 0;
        prev = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) nb = 0;
            else if (bif.tx_reg === 1'b0) begin
                if (nb % 10 != 0) chk("byte_spacing", cyc - prev, 10 * B);
                prev = cyc;
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    b[i] = bif.tx_reg;
                end
                repeat (B) @(negedge clk);
                stop = bif.tx_reg;
                if (mon_en) begin
                    chk("stop_bit", stop, 1);
                    if (exp_q.size() == 0) chk("unexpected_byte", b, 9'h100);
                    else chk("frame_byte", b, exp_q.pop_front());
                    nb++;
                end
            end
        end
    end
    task automatic start_req(input logic [19:0] d, input logic [7:0] s, input logic [79:0] e);
        for (int i = 0; i < 10; i++) exp_q.push_back(e[79 - 8 * i -: 8]);
        @(negedge clk);
        bif.dec = d;
        bif.sign = s;
        bif.uart_we = 1'b1;
        c0 = cyc;
    endtask
    task automatic wait_start();
        int n;
        n = 0;
        while (bif.tx_reg !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", bif.tx_reg, 0);
        chk("start_latency", cyc - c0, 3);
        st_cyc = cyc;
    endtask
    task automatic wait_end();
        int n;
        n = 0;
        while (bif.uart_end !== 1'b1 && n < 200 * B) begin
            @(negedge clk);
            n++;
        end
        chk("end_seen", bif.uart_end, 1);
        chk("end_timing", cyc - st_cyc, 100 * B + 1);
        chk("bytes_left", exp_q.size(), 0);
    endtask
    task automatic release_req();
        int lows;
        int ends;
        lows = 0;
        ends = 0;
        repeat (2000) begin
            @(negedge clk);
            lows += bif.tx_reg ? 0 : 1;
            ends += bif.uart_end ? 1 : 0;
        end
        chk("no_retrigger", lows, 0);
        chk("end_held", ends, 2000);
        bif.uart_we = 1'b0;
        @(negedge clk);
        chk("end_drop", bif.uart_end, 0);
        repeat (5) @(negedge clk);
    endtask
    initial begin
        int lows;
        int ends;
        int n;
        vecs[0] = '{20'h05000, 8'h2B, 80'h2B30352E303030560D0A};
        vecs[1] = '{20'h12345, 8'h2D, 80'h2D31322E333435560D0A};
        vecs[2] = '{20'h0A000, 8'h2B, 80'h2B303F2E303030560D0A};
        vecs[3] = '{20'h9F0F9, 8'h2D, 80'h2D393F2E303F39560D0A};
        vecs[4] = '{20'h99999, 8'h2B, 80'h2B39392E393939560D0A};
        bif.dec = 20'd0;
        bif.sign = 8'h2B;
        bif.uart_we = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", bif.tx_reg, 1);
        chk("reset_end", bif.uart_end, 0);
        rst_n = 1'b1;
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            lows += bif.tx_reg ? 0 : 1;
        end
        chk("idle_line", lows, 0);
        for (int v = 0; v < 5; v++) begin
            start_req(vecs[v].dec, vecs[v].sign, vecs[v].exp);
            wait_start();
            wait_end();
            release_req();
        end
        start_req(vecs[1].dec, vecs[1].sign, vecs[1].exp);
        wait_start();
        repeat (30 * B) @(negedge clk);
        bif.dec = 20'h99999;
        bif.sign = 8'h2B;
        wait_end();
        release_req();
        start_req(vecs[0].dec, vecs[0].sign, vecs[0].exp);
        wait_start();
        repeat (42 * B) @(negedge clk);
        bif.uart_we = 1'b0;
        ends = 0;
        repeat (70 * B) begin
            @(negedge clk);
            ends += bif.uart_end ? 1 : 0;
        end
        chk("dropped_no_end", ends, 0);
        chk("dropped_bytes_left", exp_q.size(), 0);
        start_req(vecs[3].dec, vecs[3].sign, vecs[3].exp);
        wait_start();
        repeat (55 * B) @(negedge clk);
        n = 0;
        while (bif.tx_reg !== 1'b0 && n < 10 * B) begin
            @(negedge clk);
            n++;
        end
        chk("mid_frame_low", bif.tx_reg, 0);
        mon_en = 1'b0;
        rst_n = 1'b0;
        bif.uart_we = 1'b0;
        #1;
        chk("async_reset_tx", bif.tx_reg, 1);
        chk("async_reset_end", bif.uart_end, 0);
        exp_q.delete();
        repeat (12 * B) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        start_req(vecs[2].dec, vecs[2].sign, vecs[2].exp);
        wait_start();
        wait_end();
        release_req();
        for (int i = 0; i < 10; i++) exp_q.push_back(vecs[4].exp[79 - 8 * i -: 8]);
        @(negedge clk);
        rst_n = 1'b0;
        bif.dec = vecs[4].dec;
        bif.sign = vecs[4].sign;
        bif.uart_we = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        wait_start();
        wait_end();
        release_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
